pipe_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RV32I pipeline. It watches the register-address and control fields in the D, E, M and W stages. From them it generates per-stage stall and flush enables for the F/D, D/E, E/M and M/W pipeline registers, plus the E-stage operand forwarding selects. It also owns the data-memory wait-state handshake, with a timeout, for loads and stores sitting in M.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/fwd_sel.sv | 23 ++
 rtl/pipe_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the RV32I pipeline control path: writeback selects,
// forwarding selects and the data-memory handshake FSM states.
package pipe_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01,
    TOUT = 2'b10
  } state_e;

endpackage

// File: rtl/fwd_sel.sv
// E-stage operand forwarding select for one source operand.
// The M stage has priority over W because it holds the younger result.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] rs_addr_i,
  input  logic [4:0] rd_addrM_i,
  input  logic       rd_wr_enM_i,
  input  logic [4:0] rd_addrW_i,
  input  logic       rd_wr_enW_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (rd_wr_enM_i && (rd_addrM_i != 5'd0) && (rd_addrM_i == rs_addr_i)) begin
      fwd_o = FWD_M;
    end else if (rd_wr_enW_i && (rd_addrW_i != 5'd0) && (rd_addrW_i == rs_addr_i)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: stalls,
// flushes, E-stage forwarding and the data-memory wait/timeout handshake.
//
// state | meaning
// RUN   | no memory wait in progress (first low-ready cycle is also stalled here)
// WAIT  | M-stage access waiting on dmem_ready, cnt tracks stalled cycles
// TOUT  | access abandoned: one-cycle mem_err, M result discarded, pipe advances
module pipe_ctrl #(
  parameter int         TIMEOUT = 16,
  parameter logic [1:0] WB_MEM  = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_addrD,
  input  logic [4:0] rs2_addrD,
  input  logic [4:0] rs1_addrE,
  input  logic [4:0] rs2_addrE,
  input  logic [4:0] rd_addrE,
  input  logic       rd_wr_enE,
  input  logic [1:0] wb_selE,
  input  logic       pc_selE,
  input  logic [4:0] rd_addrM,
  input  logic       rd_wr_enM,
  input  logic [1:0] wb_selM,
  input  logic       mem_wr_enM,
  input  logic [4:0] rd_addrW,
  input  logic       rd_wr_enW,
  input  logic       dmem_ready,
  output logic       dmem_req,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushW,
  output logic [1:0] fwd_aE,
  output logic [1:0] fwd_bE,
  output logic       mem_err
);

  import pipe_pkg::*;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       mem_m;
  logic       mwait;
  logic       lu;

  assign mem_m    = (wb_selM == WB_MEM) | mem_wr_enM;
  assign dmem_req = mem_m & (state_q != TOUT);
  assign mwait    = dmem_req & ~dmem_ready;
  assign lu       = (wb_selE == WB_MEM) & rd_wr_enE & (rd_addrE != 5'd0) &
                    ((rd_addrE == rs1_addrD) | (rd_addrE == rs2_addrD));

  // cnt counts stalled cycles of the current access, including the one spent
  // in RUN, so the abort fires after exactly TIMEOUT low-ready cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (mwait) begin
            state_q <= WAIT;
            cnt_q   <= 8'd1;
          end else begin
            cnt_q   <= 8'd0;
          end
        end
        WAIT: begin
          if (!mwait) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= TOUT;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  assign mem_err = (state_q == TOUT);

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (mwait) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (state_q == TOUT) begin
      flushW = 1'b1;
    end else if (pc_selE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (lu) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  fwd_sel u_fwd_a (
    .rs_addr_i   (rs1_addrE),
    .rd_addrM_i  (rd_addrM),
    .rd_wr_enM_i (rd_wr_enM),
    .rd_addrW_i  (rd_addrW),
    .rd_wr_enW_i (rd_wr_enW),
    .fwd_o       (fwd_aE)
  );

  fwd_sel u_fwd_b (
    .rs_addr_i   (rs2_addrE),
    .rd_addrM_i  (rd_addrM),
    .rd_wr_enM_i (rd_wr_enM),
    .rd_addrW_i  (rd_addrW),
    .rd_wr_enW_i (rd_wr_enW),
    .fwd_o       (fwd_bE)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (TIMEOUT = 4): expected output vectors are
// queued as each cycle's stimulus is driven and popped when outputs are sampled.
module tb_pipe_ctrl;

  typedef struct packed {
    logic [4:0] rs1D;
    logic [4:0] rs2D;
    logic [4:0] rs1E;
    logic [4:0] rs2E;
    logic [4:0] rdE;
    logic       wrE;
    logic [1:0] wbE;
    logic       pcsel;
    logic [4:0] rdM;
    logic       wrM;
    logic [1:0] wbM;
    logic       mwrM;
    logic [4:0] rdW;
    logic       wrW;
    logic       rdy;
  } stim_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rd_addrE, rd_addrM, rd_addrW;
  logic       rd_wr_enE, pc_selE, rd_wr_enM, mem_wr_enM, rd_wr_enW, dmem_ready;
  logic [1:0] wb_selE, wb_selM;
  logic       dmem_req, stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err;
  logic [1:0] fwd_aE, fwd_bE;

  logic [12:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  pipe_ctrl #(.TIMEOUT(4), .WB_MEM(2'b01)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1_addrD  (rs1_addrD),
    .rs2_addrD  (rs2_addrD),
    .rs1_addrE  (rs1_addrE),
    .rs2_addrE  (rs2_addrE),
    .rd_addrE   (rd_addrE),
    .rd_wr_enE  (rd_wr_enE),
    .wb_selE    (wb_selE),
    .pc_selE    (pc_selE),
    .rd_addrM   (rd_addrM),
    .rd_wr_enM  (rd_wr_enM),
    .wb_selM    (wb_selM),
    .mem_wr_enM (mem_wr_enM),
    .rd_addrW   (rd_addrW),
    .rd_wr_enW  (rd_wr_enW),
    .dmem_ready (dmem_ready),
    .dmem_req   (dmem_req),
    .stallF     (stallF),
    .stallD     (stallD),
    .stallE     (stallE),
    .stallM     (stallM),
    .flushD     (flushD),
    .flushE     (flushE),
    .flushW     (flushW),
    .fwd_aE     (fwd_aE),
    .fwd_bE     (fwd_bE),
    .mem_err    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish before 200000");
    $fatal(1);
  end

  // {req, stallF..stallM, flushD, flushE, flushW, fwd_a, fwd_b, mem_err}
  function automatic logic [12:0] ev(input logic req, input logic [3:0] st,
                                     input logic fd, input logic fe, input logic fw,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic err);
    return {req, st, fd, fe, fw, fa, fb, err};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {dmem_req, stallF, stallD, stallE, stallM, flushD, flushE, flushW,
            fwd_aE, fwd_bE, mem_err};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rdy = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rs1_addrD  = s.rs1D;  rs2_addrD = s.rs2D;
    rs1_addrE  = s.rs1E;  rs2_addrE = s.rs2E;
    rd_addrE   = s.rdE;   rd_wr_enE = s.wrE;  wb_selE = s.wbE;  pc_selE = s.pcsel;
    rd_addrM   = s.rdM;   rd_wr_enM = s.wrM;  wb_selM = s.wbM;  mem_wr_enM = s.mwrM;
    rd_addrW   = s.rdW;   rd_wr_enW = s.wrW;  dmem_ready = s.rdy;
  endtask

  task automatic test_reset();
    logic [12:0] e, o;
    rst_n = 1'b0;
    apply(idle());
    exp_q.push_back(13'd0);
    #3;
    o = obs_vec(); e = exp_q.pop_front(); n_chk++;
    if (o !== e) $display("FAIL reset_active: got %b want %b", o, e); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.push_back(13'd0);
    @(negedge clk);
    o = obs_vec(); e = exp_q.pop_front(); n_chk++;
    if (o !== e) $display("FAIL reset_release: got %b want %b", o, e); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    stim_t st[7];
    logic [12:0] ex[7];
    logic [12:0] e, o;
    foreach (st[i]) st[i] = idle();
    st[0].rdM = 5; st[0].wrM = 1; st[0].rs1E = 5; st[0].rs2E = 3;
    ex[0] = ev(0, 4'b0000, 0, 0, 0, 2'b01, 2'b00, 0);
    st[1].rdW = 5; st[1].wrW = 1; st[1].rdM = 8; st[1].wrM = 1; st[1].rs1E = 1; st[1].rs2E = 2;
    ex[1] = 13'd0;
    st[2].rdM = 9; st[2].wrM = 1; st[2].rdW = 5; st[2].wrW = 1; st[2].rs1E = 5;
    ex[2] = ev(0, 4'b0000, 0, 0, 0, 2'b10, 2'b00, 0);
    st[3].rdM = 0; st[3].wrM = 1; st[3].rdW = 0; st[3].wrW = 1;
    ex[3] = 13'd0;
    st[4].rdM = 5; st[4].wrM = 1; st[4].rdW = 5; st[4].wrW = 1; st[4].rs2E = 5;
    ex[4] = ev(0, 4'b0000, 0, 0, 0, 2'b00, 2'b01, 0);
    st[5].rdM = 5; st[5].wrM = 0; st[5].rdW = 5; st[5].wrW = 1; st[5].rs1E = 5; st[5].rs2E = 5;
    ex[5] = ev(0, 4'b0000, 0, 0, 0, 2'b10, 2'b10, 0);
    st[6].rdW = 31; st[6].wrW = 1; st[6].rs2E = 31; st[6].rdM = 12; st[6].wrM = 1; st[6].rs1E = 12;
    ex[6] = ev(0, 4'b0000, 0, 0, 0, 2'b01, 2'b10, 0);
    for (int i = 0; i < 7; i++) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      o = obs_vec(); e = exp_q.pop_front(); n_chk++;
      if (o !== e) $display("FAIL forward[%0d]: got %b want %b", i, o, e); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t st[7];
    logic [12:0] ex[7];
    logic [12:0] e, o;
    foreach (st[i]) st[i] = idle();
    st[0].rdE = 7; st[0].wrE = 1; st[0].wbE = 2'b01; st[0].rs2D = 7;
    ex[0] = ev(0, 4'b1100, 0, 1, 0, 2'b00, 2'b00, 0);
    st[1].rs2D = 7; st[1].rdM = 7; st[1].wrM = 1; st[1].wbM = 2'b01;
    ex[1] = ev(1, 4'b0000, 0, 0, 0, 2'b00, 2'b00, 0);
    st[2].rs2E = 7; st[2].rdW = 7; st[2].wrW = 1;
    ex[2] = ev(0, 4'b0000, 0, 0, 0, 2'b00, 2'b10, 0);
    st[3].rdE = 0; st[3].wrE = 1; st[3].wbE = 2'b01;
    ex[3] = 13'd0;
    st[4].rdE = 7; st[4].wrE = 1; st[4].wbE = 2'b00; st[4].rs1D = 7;
    ex[4] = 13'd0;
    st[5].rdE = 7; st[5].wrE = 1; st[5].wbE = 2'b01; st[5].rs1D = 7;
    ex[5] = ev(0, 4'b1100, 0, 1, 0, 2'b00, 2'b00, 0);
    st[6].rdE = 7; st[6].wrE = 0; st[6].wbE = 2'b01; st[6].rs1D = 7;
    ex[6] = 13'd0;
    for (int i = 0; i < 7; i++) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      o = obs_vec(); e = exp_q.pop_front(); n_chk++;
      if (o !== e) $display("FAIL load_use[%0d]: got %b want %b", i, o, e); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    stim_t st[3];
    logic [12:0] ex[3];
    logic [12:0] e, o;
    foreach (st[i]) st[i] = idle();
    st[0].pcsel = 1; st[0].rdE = 7; st[0].wrE = 1; st[0].wbE = 2'b01; st[0].rs2D = 7;
    ex[0] = ev(0, 4'b0000, 1, 1, 0, 2'b00, 2'b00, 0);
    st[1].pcsel = 1;
    ex[1] = ev(0, 4'b0000, 1, 1, 0, 2'b00, 2'b00, 0);
    ex[2] = 13'd0;
    for (int i = 0; i < 3; i++) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      o = obs_vec(); e = exp_q.pop_front(); n_chk++;
      if (o !== e) $display("FAIL branch[%0d]: got %b want %b", i, o, e); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  // Ready rises on the 4th cycle, i.e. exactly when the count hits TIMEOUT-1.
  task automatic test_mem_wait();
    stim_t st[8];
    logic [12:0] ex[8];
    logic [12:0] e, o;
    foreach (st[i]) st[i] = idle();
    for (int i = 0; i < 4; i++) begin
      st[i].rdM = 7; st[i].wrM = 1; st[i].wbM = 2'b01; st[i].rs1E = 7;
      st[i].pcsel = 1; st[i].rdE = 9; st[i].wrE = 1; st[i].wbE = 2'b01; st[i].rs2D = 9;
      st[i].rdy = (i == 3);
      ex[i] = (i == 3) ? ev(1, 4'b0000, 1, 1, 0, 2'b01, 2'b00, 0)
                       : ev(1, 4'b1111, 0, 0, 1, 2'b01, 2'b00, 0);
    end
    ex[4] = 13'd0;
    st[5].mwrM = 1; st[5].rdy = 0;
    ex[5] = ev(1, 4'b1111, 0, 0, 1, 2'b00, 2'b00, 0);
    st[6].mwrM = 1; st[6].rdy = 1;
    ex[6] = ev(1, 4'b0000, 0, 0, 0, 2'b00, 2'b00, 0);
    ex[7] = 13'd0;
    for (int i = 0; i < 8; i++) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      o = obs_vec(); e = exp_q.pop_front(); n_chk++;
      if (o !== e) $display("FAIL mem_wait[%0d]: got %b want %b", i, o, e); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    stim_t st[6];
    logic [12:0] ex[6];
    logic [12:0] e, o;
    foreach (st[i]) st[i] = idle();
    for (int i = 0; i < 5; i++) begin
      st[i].rdM = 3; st[i].mwrM = 1; st[i].rdy = 0;
      ex[i] = ev(1, 4'b1111, 0, 0, 1, 2'b00, 2'b00, 0);
    end
    st[4].pcsel = 1;
    ex[4] = ev(0, 4'b0000, 0, 0, 1, 2'b00, 2'b00, 1);
    ex[5] = 13'd0;
    for (int i = 0; i < 6; i++) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      o = obs_vec(); e = exp_q.pop_front(); n_chk++;
      if (o !== e) $display("FAIL timeout[%0d]: got %b want %b", i, o, e); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_wait();
    stim_t ld;
    logic [12:0] stall_v, e, o;
    ld = idle();
    ld.rdM = 7; ld.wrM = 1; ld.wbM = 2'b01; ld.rdy = 0;
    stall_v = ev(1, 4'b1111, 0, 0, 1, 2'b00, 2'b00, 0);
    for (int i = 0; i < 2; i++) begin
      apply(ld); exp_q.push_back(stall_v);
      @(negedge clk);
      o = obs_vec(); e = exp_q.pop_front(); n_chk++;
      if (o !== e) $display("FAIL rst_wait_pre[%0d]: got %b want %b", i, o, e); else n_pass++;
      @(posedge clk); #1;
    end
    // Second WAIT cycle: pull reset mid-cycle.
    apply(ld); exp_q.push_back(stall_v);
    #2 rst_n = 1'b0;
    #1;
    o = obs_vec(); e = exp_q.pop_front(); n_chk++;
    if (o !== e) $display("FAIL rst_wait_async: got %b want %b", o, e); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    // Counter must restart from zero: full TIMEOUT stall cycles before abort.
    for (int i = 0; i < 6; i++) begin
      apply((i == 5) ? idle() : ld);
      exp_q.push_back((i < 4) ? stall_v :
                      (i == 4) ? ev(0, 4'b0000, 0, 0, 1, 2'b00, 2'b00, 1) : 13'd0);
      @(negedge clk);
      o = obs_vec(); e = exp_q.pop_front(); n_chk++;
      if (o !== e) $display("FAIL rst_wait_post[%0d]: got %b want %b", i, o, e); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
